// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 serial receiver for a line that is already synchronised
// to i_clk. The start bit is confirmed at its midpoint, and every later bit
// is sampled one bit-time after that. Each received byte waits in a
// single-entry holding register until the consumer acknowledges it.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_synchLine,
    input  logic       i_ack,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frameErr,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Counter value at the midpoint of the start bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    // Counter value one full bit-time after the previous sample point.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       index_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       data_reg;
    logic             valid_reg;
    logic             frame_err_reg;
    logic             overrun_reg;

    logic             half_tick;
    logic             bit_tick;
    logic             good_frame;

    // Sample-point strobes and the good-frame qualifier that feeds the holding register.
    assign half_tick  = (cnt_reg == HALF_LAST);
    assign bit_tick   = (cnt_reg == BIT_LAST);
    assign good_frame = (state_reg == STOP) && bit_tick && i_synchLine;

    // Receive FSM, holding register and status flags, all in one registered process.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            index_reg     <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            // The frame error flag is a single-cycle pulse.
            frame_err_reg <= 1'b0;

            // A completing frame takes priority over a plain acknowledge.
            // An acknowledge on the same edge frees the slot for the new byte.
            if (good_frame) begin
                if (!valid_reg || i_ack) begin
                    data_reg  <= shift_reg;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (i_ack) begin
                valid_reg   <= 1'b0;
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (!i_synchLine) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end

                START: begin
                    if (half_tick) begin
                        cnt_reg <= '0;
                        if (!i_synchLine) begin
                            state_reg <= DATA;
                            index_reg <= '0;
                        end else begin
                            // The line went high again before mid-bit, so this was a glitch.
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_tick) begin
                        shift_reg[index_reg] <= i_synchLine;
                        cnt_reg              <= '0;
                        if (index_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            index_reg <= index_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (bit_tick) begin
                        cnt_reg <= '0;
                        if (i_synchLine) begin
                            state_reg <= IDLE;
                        end else begin
                            // Low stop bit: drop the byte and wait out the break.
                            frame_err_reg <= 1'b1;
                            state_reg     <= BREAK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                BREAK: begin
                    if (i_synchLine) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign o_data     = data_reg;
    assign o_valid    = valid_reg;
    assign o_frameErr = frame_err_reg;
    assign o_overrun  = overrun_reg;
    assign o_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at the default 16 clocks per bit.
module tb_uart_rx;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       line = 1'b1;
    logic       ack  = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frameErr;
    logic       o_overrun;
    logic       o_busy;

    int n_vec = 0;
    int n_err = 0;

    int   edge_cnt        = 0;
    int   valid_rise_edge = -1;
    int   ferr_cnt        = 0;
    int   busy_cnt        = 0;
    logic prev_valid      = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_synchLine(line),
        .i_ack      (ack),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frameErr (o_frameErr),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    // Numbers each rising edge and records output activity 1 time unit later.
    always @(posedge clk) begin
        edge_cnt++;
        #1;
        if (o_valid && !prev_valid) valid_rise_edge = edge_cnt;
        prev_valid = o_valid;
        if (o_frameErr) ferr_cnt++;
        if (o_busy) busy_cnt++;
    end

    // Drives one frame. This task must be entered at a falling edge. The start
    // bit is first sampled at edge start_edge. stop_low>0 holds the stop bit low
    // for that many cycles. The acknowledge is raised for the edge start_edge+ack_k.
    task automatic send_frame(input logic [7:0] b, input int stop_low,
                              input int ack_k, output int start_edge);
        int total;
        total = (stop_low > 0) ? 144 + stop_low : 160;
        start_edge = edge_cnt + 1;
        for (int k = 0; k < total; k++) begin
            if (k < 16)       line = 1'b0;
            else if (k < 144) line = b[(k - 16) / 16];
            else              line = (stop_low > 0) ? 1'b0 : 1'b1;
            ack = (k == ack_k);
            @(negedge clk);
        end
        line = 1'b1;
        ack  = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_vec++; if (o_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", o_data); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_vec++; if (o_frameErr !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", o_frameErr); end
        n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        repeat (3) @(negedge clk);
        // The first edge after release must already see the low line.
        rst  = 1'b0;
        line = 1'b0;
        @(negedge clk);
        n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL first_edge_busy: got %b want 1", o_busy); end
        line = 1'b1;
        repeat (20) @(negedge clk);
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL first_edge_idle: got %b want 0", o_busy); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL first_edge_valid: got %b want 0", o_valid); end
        $display("test_reset done");
    endtask

    task automatic test_glitch();
        busy_cnt = 0;
        ferr_cnt = 0;
        line = 1'b0;
        repeat (7) @(negedge clk);
        line = 1'b1;
        repeat (20) @(negedge clk);
        n_vec++; if (busy_cnt !== 8) begin n_err++; $display("FAIL glitch_busy_cycles: got %0d want 8", busy_cnt); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got %b want 0", o_busy); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", o_valid); end
        n_vec++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); end
        n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL glitch_overrun: got %b want 0", o_overrun); end
        $display("test_glitch done");
    endtask

    task automatic test_receive();
        int s;
        valid_rise_edge = -1;
        ferr_cnt = 0;
        send_frame(8'hA5, 0, -1, s);
        n_vec++; if (o_data !== 8'hA5) begin n_err++; $display("FAIL rx_data: got %h want a5", o_data); end
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL rx_valid: got %b want 1", o_valid); end
        n_vec++; if (valid_rise_edge !== s + 152) begin n_err++; $display("FAIL rx_latency: got edge %0d want %0d", valid_rise_edge, s + 152); end
        n_vec++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL rx_ferr: got %0d want 0", ferr_cnt); end
        pulse_ack();
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rx_ack_valid: got %b want 0", o_valid); end
        $display("test_receive A5 start_edge=%0d valid_edge=%0d", s, valid_rise_edge);
    endtask

    task automatic test_frame_error();
        int s;
        ferr_cnt = 0;
        send_frame(8'h3C, 48, -1, s);
        n_vec++; if (ferr_cnt !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid: got %b want 0", o_valid); end
        n_vec++; if (o_data !== 8'hA5) begin n_err++; $display("FAIL ferr_data_kept: got %h want a5", o_data); end
        n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL ferr_overrun: got %b want 0", o_overrun); end
        n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy: got %b want 1", o_busy); end
        @(negedge clk);
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL ferr_break_exit: got %b want 0", o_busy); end
        $display("test_frame_error 3C start_edge=%0d", s);
    endtask

    task automatic test_back_to_back();
        int s1;
        int s2;
        ferr_cnt = 0;
        send_frame(8'h11, 0, -1, s1);
        send_frame(8'h22, 0, -1, s2);
        n_vec++; if (s2 !== s1 + 160) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", s2 - s1, 160); end
        n_vec++; if (o_data !== 8'h11) begin n_err++; $display("FAIL b2b_data: got %h want 11", o_data); end
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", o_valid); end
        n_vec++; if (o_overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun: got %b want 1", o_overrun); end
        n_vec++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt); end
        pulse_ack();
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_ack_valid: got %b want 0", o_valid); end
        n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL b2b_ack_overrun: got %b want 0", o_overrun); end
        $display("test_back_to_back 11,22");
    endtask

    task automatic test_ack_same_cycle();
        int s;
        send_frame(8'h11, 0, -1, s);
        n_vec++; if (o_data !== 8'h11) begin n_err++; $display("FAIL same_first_data: got %h want 11", o_data); end
        send_frame(8'h22, 0, 152, s);
        n_vec++; if (o_data !== 8'h22) begin n_err++; $display("FAIL same_data: got %h want 22", o_data); end
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL same_valid: got %b want 1", o_valid); end
        n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL same_overrun: got %b want 0", o_overrun); end
        $display("test_ack_same_cycle 11,22");
    endtask

    task automatic test_async_reset();
        int s;
        // Set the overrun flag first so that the reset has something to clear.
        send_frame(8'h33, 0, -1, s);
        n_vec++; if (o_overrun !== 1'b1) begin n_err++; $display("FAIL arst_pre_overrun: got %b want 1", o_overrun); end
        // Drive the start bit plus four low data bits, then stop halfway through data bit 4.
        line = 1'b0;
        repeat (88) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (o_data !== 8'h00) begin n_err++; $display("FAIL arst_data: got %h want 00", o_data); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", o_valid); end
        n_vec++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL arst_overrun: got %b want 0", o_overrun); end
        n_vec++; if (o_frameErr !== 1'b0) begin n_err++; $display("FAIL arst_ferr: got %b want 0", o_frameErr); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", o_busy); end
        line = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL arst_idle: got %b want 0", o_busy); end
        valid_rise_edge = -1;
        ferr_cnt = 0;
        send_frame(8'h5A, 0, -1, s);
        n_vec++; if (o_data !== 8'h5A) begin n_err++; $display("FAIL arst_rx_data: got %h want 5a", o_data); end
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL arst_rx_valid: got %b want 1", o_valid); end
        n_vec++; if (valid_rise_edge !== s + 152) begin n_err++; $display("FAIL arst_rx_latency: got edge %0d want %0d", valid_rise_edge, s + 152); end
        n_vec++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL arst_rx_ferr: got %0d want 0", ferr_cnt); end
        $display("test_async_reset then 5A start_edge=%0d", s);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_receive();
        test_frame_error();
        test_back_to_back();
        test_ack_same_cycle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
